// File: rtl/ram_port_arbiter_pkg.sv
// Shared owner encodings, master indices and RAM width defaults for the RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_M      = 3;

  // Master slot in the per-master request vectors
  localparam logic [1:0] M_BOOT = 2'd0;
  localparam logic [1:0] M_CPU  = 2'd1;
  localparam logic [1:0] M_DBG  = 2'd2;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_BOOT = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_DBG  = 2'd3
  } owner_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Master-side request/grant bundle plus the RAM port, shared by the arbiter and its masters.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              boot_req, boot_rw, boot_gnt, boot_rvalid;
  logic [ADDR_W-1:0] boot_adr;
  logic [DATA_W-1:0] boot_din;
  logic              cpu_req, cpu_rw, cpu_gnt, cpu_rvalid;
  logic [ADDR_W-1:0] cpu_adr;
  logic [DATA_W-1:0] cpu_din;
  logic              dbg_req, dbg_rw, dbg_gnt, dbg_rvalid;
  logic [ADDR_W-1:0] dbg_adr;
  logic [DATA_W-1:0] dbg_din;
  logic [ADDR_W-1:0] ram_adr;
  logic [DATA_W-1:0] ram_in, ram_out, rdata;
  logic              ram_rw, ram_enable;

  modport slave (
    input  boot_req, boot_rw, boot_adr, boot_din,
    input  cpu_req, cpu_rw, cpu_adr, cpu_din,
    input  dbg_req, dbg_rw, dbg_adr, dbg_din,
    input  ram_out,
    output boot_gnt, boot_rvalid, cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid,
    output ram_adr, ram_in, ram_rw, ram_enable, rdata
  );

  modport master (
    output boot_req, boot_rw, boot_adr, boot_din,
    output cpu_req, cpu_rw, cpu_adr, cpu_din,
    output dbg_req, dbg_rw, dbg_adr, dbg_din,
    output ram_out,
    input  boot_gnt, boot_rvalid, cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid,
    input  ram_adr, ram_in, ram_rw, ram_enable, rdata
  );
endinterface

// File: rtl/ram_port_arbiter_arb_rr2.sv
// Two-way round-robin pick between CPU (0) and DBG (1); on a tie the one not served last wins.
module ram_port_arbiter_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       vld,
  output logic       pick
);
  assign vld  = |req;
  assign pick = (&req) ? ~last : req[1];
endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: BOOT has absolute priority, CPU/DBG share the rest round-robin
// with a burst limit; registered grants and a per-master read-data-valid pulse.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 8
) (
  input logic               clk,
  input logic               rst,
  input logic               ce,
  ram_port_arbiter_if.slave bus
);
  localparam int              CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  logic [NUM_M-1:0]             req, rw;
  logic [NUM_M-1:0][ADDR_W-1:0] adr;
  logic [NUM_M-1:0][DATA_W-1:0] din;

  assign req = {bus.dbg_req, bus.cpu_req, bus.boot_req};
  assign rw  = {bus.dbg_rw,  bus.cpu_rw,  bus.boot_rw};
  assign adr = {bus.dbg_adr, bus.cpu_adr, bus.boot_adr};
  assign din = {bus.dbg_din, bus.cpu_din, bus.boot_din};

  owner_e           state_q, state_d, other;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_dbg_q, last_dbg_d;
  logic [NUM_M-1:0] rvalid_q, rvalid_d;
  logic [1:0]       idx;
  logic             own_req, access, rr_owner, other_req, rr_vld, rr_pick;

  ram_port_arbiter_arb_rr2 u_arb_rr2 (
    .req  ({req[M_DBG], req[M_CPU]}),
    .last (last_dbg_q),
    .vld  (rr_vld),
    .pick (rr_pick)
  );

  // Decode the current owner into its request slot and its CPU/DBG rival
  always_comb begin
    idx       = M_BOOT;
    own_req   = 1'b0;
    rr_owner  = 1'b0;
    other     = OWN_CPU;
    other_req = 1'b0;
    case (state_q)
      OWN_BOOT: begin
        idx     = M_BOOT;
        own_req = req[M_BOOT];
      end
      OWN_CPU: begin
        idx       = M_CPU;
        own_req   = req[M_CPU];
        rr_owner  = 1'b1;
        other     = OWN_DBG;
        other_req = req[M_DBG];
      end
      OWN_DBG: begin
        idx       = M_DBG;
        own_req   = req[M_DBG];
        rr_owner  = 1'b1;
        other     = OWN_CPU;
        other_req = req[M_CPU];
      end
      default: ;
    endcase
    access = ce & own_req;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dbg_d = last_dbg_q;
    rvalid_d   = rvalid_q;
    if (ce) begin
      rvalid_d = '0;
      if (access && !rw[idx]) rvalid_d[idx] = 1'b1;

      if (req[M_BOOT])
        state_d = OWN_BOOT;
      else if (rr_owner && own_req)
        // A busy owner keeps the port until its burst is used up and the rival is waiting
        state_d = (cnt_q == CNT_MAX && other_req) ? other : state_q;
      else if (rr_vld)
        state_d = rr_pick ? OWN_DBG : OWN_CPU;
      else
        state_d = OWN_IDLE;

      if (state_d != state_q)
        cnt_d = '0;
      else if (access && rr_owner && cnt_q != CNT_MAX)
        cnt_d = cnt_q + 1'b1;

      if (state_d == OWN_CPU)      last_dbg_d = 1'b0;
      else if (state_d == OWN_DBG) last_dbg_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= OWN_IDLE;
      cnt_q      <= '0;
      last_dbg_q <= 1'b1;
      rvalid_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_dbg_q <= last_dbg_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign bus.boot_gnt    = (state_q == OWN_BOOT);
  assign bus.cpu_gnt     = (state_q == OWN_CPU);
  assign bus.dbg_gnt     = (state_q == OWN_DBG);
  assign bus.boot_rvalid = rvalid_q[M_BOOT];
  assign bus.cpu_rvalid  = rvalid_q[M_CPU];
  assign bus.dbg_rvalid  = rvalid_q[M_DBG];

  assign bus.ram_enable = access;
  assign bus.ram_rw     = access & rw[idx];
  assign bus.ram_adr    = access ? adr[idx] : '0;
  assign bus.ram_in     = access ? din[idx] : '0;
  assign bus.rdata      = bus.ram_out;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against an owner/burst/memory model.
module tb_ram_port_arbiter;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int MB = 8;

  logic clk = 1'b0;
  logic rst, ce;
  int   n_chk = 0;
  int   n_fail = 0;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous, gated by ce
  bit [DW-1:0] ram [64];
  always @(posedge clk) begin
    if (ce && bus.ram_enable) begin
      if (bus.ram_rw) ram[bus.ram_adr] <= bus.ram_in;
      else            bus.ram_out      <= ram[bus.ram_adr];
    end
  end

  // Reference model: 0 idle, 1 boot, 2 cpu, 3 dbg
  int          m_own, m_cnt, m_last;
  bit [2:0]    m_rv;
  bit [DW-1:0] m_rdata;
  bit [DW-1:0] m_mem [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit req_of(int o);
    case (o)
      1: return bus.boot_req;
      2: return bus.cpu_req;
      3: return bus.dbg_req;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit rw_of(int o);
    case (o)
      1: return bus.boot_rw;
      2: return bus.cpu_rw;
      default: return bus.dbg_rw;
    endcase
  endfunction

  function automatic int adr_of(int o);
    case (o)
      1: return int'(bus.boot_adr);
      2: return int'(bus.cpu_adr);
      default: return int'(bus.dbg_adr);
    endcase
  endfunction

  function automatic int din_of(int o);
    case (o)
      1: return int'(bus.boot_din);
      2: return int'(bus.cpu_din);
      default: return int'(bus.dbg_din);
    endcase
  endfunction

  function automatic bit [2:0] onehot(int o);
    return (o == 0) ? 3'b000 : 3'(1 << (o - 1));
  endfunction

  task automatic model_reset();
    m_own = 0; m_cnt = 0; m_last = 3; m_rv = '0;
  endtask

  task automatic check_outputs();
    bit acc;
    acc = ce && req_of(m_own);
    chk("gnt", {bus.dbg_gnt, bus.cpu_gnt, bus.boot_gnt}, onehot(m_own));
    chk("ram_enable", bus.ram_enable, acc);
    chk("ram_rw",  bus.ram_rw,  acc ? rw_of(m_own) : 1'b0);
    chk("ram_adr", bus.ram_adr, acc ? adr_of(m_own) : 0);
    chk("ram_in",  bus.ram_in,  acc ? din_of(m_own) : 0);
    chk("rvalid", {bus.dbg_rvalid, bus.cpu_rvalid, bus.boot_rvalid}, m_rv);
    if (m_rv != 0) chk("rdata", bus.rdata, m_rdata);
  endtask

  task automatic model_step();
    bit acc;
    int nx, other;
    if (rst || !ce) return;
    acc  = req_of(m_own);
    m_rv = '0;
    if (acc) begin
      if (rw_of(m_own)) m_mem[adr_of(m_own)] = DW'(din_of(m_own));
      else begin
        m_rv    = onehot(m_own);
        m_rdata = m_mem[adr_of(m_own)];
      end
    end
    other = 5 - m_own;
    if (bus.boot_req)                           nx = 1;
    else if (m_own >= 2 && acc)                 nx = (m_cnt == MB - 1 && req_of(other)) ? other : m_own;
    else if (bus.cpu_req && bus.dbg_req)        nx = (m_last == 2) ? 3 : 2;
    else if (bus.cpu_req)                       nx = 2;
    else if (bus.dbg_req)                       nx = 3;
    else                                        nx = 0;
    if (nx != m_own)                            m_cnt = 0;
    else if (acc && m_own >= 2 && m_cnt < MB-1) m_cnt++;
    if (nx >= 2) m_last = nx;
    m_own = nx;
  endtask

  // One clock: check at negedge, advance the model, return just after the next posedge
  task automatic cycle();
    @(negedge clk);
    if (rst) model_reset();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit b, input bit c, input bit d);
    bus.boot_req = b; bus.cpu_req = c; bus.dbg_req = d;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1;
    set_req(0, 0, 0);
    bus.boot_rw = 0; bus.cpu_rw = 0; bus.dbg_rw = 0;
    bus.boot_adr = '0; bus.cpu_adr = '0; bus.dbg_adr = '0;
    bus.boot_din = '0; bus.cpu_din = '0; bus.dbg_din = '0;
    model_reset();
    repeat (2) cycle();
    chk("rst_gnt", {bus.dbg_gnt, bus.cpu_gnt, bus.boot_gnt}, 3'b000);
    chk("rst_en", bus.ram_enable, 1'b0);
    chk("rst_adr", bus.ram_adr, 0);
    rst = 1'b0;
    cycle();

    // All three request from idle: BOOT first, then CPU with no idle gap
    set_req(1, 1, 1);
    cycle();
    chk("t6_boot_gnt", bus.boot_gnt, 1'b1);
    bus.boot_req = 1'b0;
    cycle();
    chk("t6_cpu_gnt", bus.cpu_gnt, 1'b1);
    chk("t6_cpu_en", bus.ram_enable, 1'b1);
    repeat (2) cycle();

    // Reset in the middle of a CPU burst
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt", bus.cpu_gnt, 1'b0);
    chk("mid_rst_en", bus.ram_enable, 1'b0);
    model_reset();
    cycle();
    rst = 1'b0;

    // CPU and DBG alternate in bursts of MB
    set_req(0, 1, 1);
    cycle();
    chk("t2_cpu_first", bus.cpu_gnt, 1'b1);
    repeat (MB - 1) cycle();
    chk("t2_cpu_last", bus.cpu_gnt, 1'b1);
    cycle();
    chk("t2_dbg_first", bus.dbg_gnt, 1'b1);
    repeat (MB) cycle();
    chk("t2_cpu_again", bus.cpu_gnt, 1'b1);

    // BOOT preempts a CPU burst, writes 0x1234, then CPU reads it back
    set_req(0, 1, 0);
    bus.cpu_rw = 1'b0; bus.cpu_adr = 6'h2A;
    repeat (4) cycle();
    bus.boot_req = 1'b1; bus.boot_rw = 1'b1; bus.boot_adr = 6'h2A; bus.boot_din = 16'h1234;
    cycle();
    chk("t3_boot_gnt", bus.boot_gnt, 1'b1);
    chk("t3_cpu_wait", bus.cpu_gnt, 1'b0);
    cycle();
    bus.boot_req = 1'b0;
    cycle();
    chk("t4_cpu_gnt", bus.cpu_gnt, 1'b1);
    cycle();
    chk("t4_rvalid", bus.cpu_rvalid, 1'b1);
    chk("t4_rdata", bus.rdata, 16'h1234);

    // ce low freezes the rvalid pulse and the grant
    ce = 1'b0;
    cycle();
    chk("t5_hold_rv", bus.cpu_rvalid, 1'b1);
    chk("t5_hold_en", bus.ram_enable, 1'b0);
    cycle();
    chk("t5_hold_gnt", bus.cpu_gnt, 1'b1);
    ce = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_din = 16'h5555;
    cycle();
    chk("t5_rv_drop", bus.cpu_rvalid, 1'b0);

    // Random traffic on a narrow address range so reads hit earlier writes
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      ce  = ($urandom_range(0, 7) != 0);
      bus.boot_req = ($urandom_range(0, 9) == 0);
      bus.cpu_req  = ($urandom_range(0, 3) != 0);
      bus.dbg_req  = ($urandom_range(0, 3) != 0);
      bus.boot_rw  = 1'($urandom); bus.cpu_rw = 1'($urandom); bus.dbg_rw = 1'($urandom);
      bus.boot_adr = 6'($urandom_range(0, 7));
      bus.cpu_adr  = 6'($urandom_range(0, 7));
      bus.dbg_adr  = 6'($urandom_range(0, 7));
      bus.boot_din = 16'($urandom); bus.cpu_din = 16'($urandom); bus.dbg_din = 16'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
